text_console_writer: RTL and testbench

//   Character-stream writer for the text-mode screen RAM: accepts ASCII bytes

---
 rtl/text_console_writer_pkg.sv | 36 +++
 rtl/text_console_writer_if.sv | 31 +++
 rtl/text_console_writer.sv | 145 ++++++++++++++
 tb/tb_text_console_writer.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_console_writer_pkg.sv
// ----------------------------------------------------------------------------
// text_console_writer_pkg : screen geometry, ASCII codes and FSM states
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package text_console_writer_pkg;

  localparam int COLS      = 80;
  localparam int ROWS      = 30;
  localparam int COL_BITS  = 7;
  localparam int ROW_BITS  = 5;
  localparam int ADDR_BITS = ROW_BITS + COL_BITS;

  localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(COLS - 1);
  localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(ROWS - 1);

  localparam logic [7:0] FILL_CHAR = 8'h20;
  localparam logic [7:0] ASCII_BS  = 8'h08;
  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_FF  = 8'h0C;
  localparam logic [7:0] ASCII_CR  = 8'h0D;

  typedef enum logic [1:0] {
    CLR_ALL = 2'd0,
    IDLE    = 2'd1,
    CLR_ROW = 2'd2
  } state_e;

  function automatic logic is_printable(input logic [7:0] c);
    return (c >= 8'h20) && (c <= 8'h7E);
  endfunction

endpackage

`default_nettype wire

// File: rtl/text_console_writer_if.sv
// ----------------------------------------------------------------------------
// text_console_writer_if : character input handshake, screen RAM write port
// and cursor position. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface text_console_writer_if;
  import text_console_writer_pkg::*;

  logic [7:0]           char_in;
  logic                 char_valid;
  logic                 char_ready;
  logic [ADDR_BITS-1:0] ram_addr;
  logic [7:0]           ram_wdata;
  logic                 ram_we;
  logic [COL_BITS-1:0]  cursor_col;
  logic [ROW_BITS-1:0]  cursor_row;

  modport master (
    input  char_in, char_valid,
    output char_ready, ram_addr, ram_wdata, ram_we, cursor_col, cursor_row
  );

  modport slave (
    output char_in, char_valid,
    input  char_ready, ram_addr, ram_wdata, ram_we, cursor_col, cursor_row
  );

endinterface

`default_nettype wire

// File: rtl/text_console_writer.sv
// ----------------------------------------------------------------------------
// text_console_writer : ASCII stream to text-mode screen RAM writer with
// cursor, CR/LF/BS, form-feed clear and line wrap. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module text_console_writer
  import text_console_writer_pkg::*;
(
  input  wire logic             clk,
  input  wire logic             reset,
  text_console_writer_if.master con
);

  state_e               state_q;
  logic [ROW_BITS-1:0]  sweep_row_q;
  logic [COL_BITS-1:0]  sweep_col_q;
  logic [ROW_BITS-1:0]  cur_row_q;
  logic [COL_BITS-1:0]  cur_col_q;
  logic                 we_q;
  logic [ADDR_BITS-1:0] addr_q;
  logic [7:0]           wdata_q;
  logic                 ready_q;

  logic [ROW_BITS-1:0]  row_adv_d;
  logic [COL_BITS-1:0]  col_inc_d;
  logic [COL_BITS-1:0]  col_dec_d;
  logic                 accept_d;

  // Row advance wraps to the top; the new line is blanked, never scrolled.
  assign row_adv_d = (cur_row_q == ROW_LAST) ? '0 : cur_row_q + 1'b1;
  assign col_inc_d = cur_col_q + 1'b1;
  assign col_dec_d = cur_col_q - 1'b1;
  assign accept_d  = con.char_valid && ready_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= CLR_ALL;
      sweep_row_q <= '0;
      sweep_col_q <= '0;
      cur_row_q   <= '0;
      cur_col_q   <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= FILL_CHAR;
      ready_q     <= 1'b0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        CLR_ALL: begin
          we_q    <= 1'b1;
          addr_q  <= {sweep_row_q, sweep_col_q};
          wdata_q <= FILL_CHAR;
          if (sweep_col_q == COL_LAST) begin
            sweep_col_q <= '0;
            if (sweep_row_q == ROW_LAST) begin
              sweep_row_q <= '0;
              cur_row_q   <= '0;
              cur_col_q   <= '0;
              state_q     <= IDLE;
              ready_q     <= 1'b1;
            end else begin
              sweep_row_q <= sweep_row_q + 1'b1;
            end
          end else begin
            sweep_col_q <= sweep_col_q + 1'b1;
          end
        end

        CLR_ROW: begin
          we_q    <= 1'b1;
          addr_q  <= {cur_row_q, sweep_col_q};
          wdata_q <= FILL_CHAR;
          if (sweep_col_q == COL_LAST) begin
            sweep_col_q <= '0;
            state_q     <= IDLE;
            ready_q     <= 1'b1;
          end else begin
            sweep_col_q <= sweep_col_q + 1'b1;
          end
        end

        IDLE: begin
          if (accept_d) begin
            if (is_printable(con.char_in)) begin
              we_q    <= 1'b1;
              addr_q  <= {cur_row_q, cur_col_q};
              wdata_q <= con.char_in;
              if (cur_col_q == COL_LAST) begin
                cur_col_q <= '0;
                cur_row_q <= row_adv_d;
                state_q   <= CLR_ROW;
                ready_q   <= 1'b0;
              end else begin
                cur_col_q <= col_inc_d;
              end
            end else begin
              case (con.char_in)
                ASCII_CR: cur_col_q <= '0;
                ASCII_LF: begin
                  cur_col_q <= '0;
                  cur_row_q <= row_adv_d;
                  state_q   <= CLR_ROW;
                  ready_q   <= 1'b0;
                end
                ASCII_BS: begin
                  if (cur_col_q != '0) begin
                    cur_col_q <= col_dec_d;
                    we_q      <= 1'b1;
                    addr_q    <= {cur_row_q, col_dec_d};
                    wdata_q   <= FILL_CHAR;
                  end
                end
                ASCII_FF: begin
                  sweep_row_q <= '0;
                  sweep_col_q <= '0;
                  state_q     <= CLR_ALL;
                  ready_q     <= 1'b0;
                end
                default: ;
              endcase
            end
          end
        end

        default: begin
          sweep_row_q <= '0;
          sweep_col_q <= '0;
          state_q     <= CLR_ALL;
          ready_q     <= 1'b0;
        end
      endcase
    end
  end

  assign con.char_ready = ready_q;
  assign con.ram_we     = we_q;
  assign con.ram_addr   = addr_q;
  assign con.ram_wdata  = wdata_q;
  assign con.cursor_col = cur_col_q;
  assign con.cursor_row = cur_row_q;

endmodule

`default_nettype wire

// File: tb/tb_text_console_writer.sv
// ----------------------------------------------------------------------------
// tb_text_console_writer : self-checking bench for text_console_writer
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_text_console_writer;

  localparam int NCOLS = 80;
  localparam int NROWS = 30;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } wr_t;

  typedef struct {
    logic [7:0] c;
    int         col;
    int         row;
    int         nwr;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  text_console_writer_if intf();

  text_console_writer dut (
    .clk   (clk),
    .reset (reset),
    .con   (intf)
  );

  int  checks = 0;
  int  errors = 0;
  wr_t obs_q[$];
  wr_t exp_q[$];
  int  rd = 0;
  int  cyc = 0;
  int  m_row = 0;
  int  m_col = 0;
  vec_t tbl[13];

  // Writes are captured mid-cycle, away from the active edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (intf.ram_we)
      obs_q.push_back('{int'(intf.ram_addr), int'(intf.ram_wdata), cyc});
  end

  task automatic chk_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  function automatic wr_t obs_at(input int i);
    wr_t w = '{-1, -1, 0};
    if (i < obs_q.size()) w = obs_q[i];
    return w;
  endfunction

  // Reference model: screen rules expressed as a list of expected writes.
  task automatic m_push(input int row, input int col, input int data);
    exp_q.push_back('{row * 128 + col, data, 0});
  endtask

  task automatic m_advance();
    m_row = (m_row == NROWS - 1) ? 0 : m_row + 1;
    for (int c = 0; c < NCOLS; c++) m_push(m_row, c, 'h20);
  endtask

  task automatic m_clear_all();
    for (int r = 0; r < NROWS; r++)
      for (int c = 0; c < NCOLS; c++) m_push(r, c, 'h20);
    m_row = 0;
    m_col = 0;
  endtask

  task automatic model(input logic [7:0] ch);
    if (ch >= 8'h20 && ch <= 8'h7E) begin
      m_push(m_row, m_col, int'(ch));
      if (m_col == NCOLS - 1) begin
        m_col = 0;
        m_advance();
      end else begin
        m_col++;
      end
    end else if (ch == 8'h0D) begin
      m_col = 0;
    end else if (ch == 8'h0A) begin
      m_col = 0;
      m_advance();
    end else if (ch == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        m_push(m_row, m_col, 'h20);
      end
    end else if (ch == 8'h0C) begin
      m_clear_all();
    end
  endtask

  task automatic send(input logic [7:0] ch);
    int n = 0;
    intf.char_in    = ch;
    intf.char_valid = 1'b1;
    while (!intf.char_ready && n < 6000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 6000) fail_now("send_ready_timeout");
    @(posedge clk);
    #1;
    intf.char_valid = 1'b0;
    model(ch);
  endtask

  task automatic settle();
    int n = 0;
    @(negedge clk);
    while (!intf.char_ready && n < 6000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 6000) fail_now("settle_timeout");
    @(negedge clk);
  endtask

  task automatic check_writes(input string tag);
    wr_t o;
    wr_t e;
    while (rd < obs_q.size() && exp_q.size() > 0) begin
      o = obs_q[rd];
      rd++;
      e = exp_q.pop_front();
      chk_eq({tag, "_addr"}, o.addr, e.addr);
      chk_eq({tag, "_data"}, o.data, e.data);
    end
    chk_eq({tag, "_extra_writes"}, obs_q.size() - rd, 0);
    chk_eq({tag, "_missing_writes"}, exp_q.size(), 0);
    rd = obs_q.size();
    exp_q.delete();
  endtask

  task automatic check_cursor(input string tag, input int row, input int col);
    chk_eq({tag, "_row"}, int'(intf.cursor_row), row);
    chk_eq({tag, "_col"}, int'(intf.cursor_col), col);
  endtask

  task automatic check_reset_state(input string tag);
    chk_eq({tag, "_ready"}, int'(intf.char_ready), 0);
    chk_eq({tag, "_we"}, int'(intf.ram_we), 0);
    chk_eq({tag, "_addr"}, int'(intf.ram_addr), 0);
    chk_eq({tag, "_wdata"}, int'(intf.ram_wdata), 'h20);
    check_cursor(tag, 0, 0);
  endtask

  initial begin
    int n0;
    int n;
    int r;
    logic [7:0] ch;
    wr_t w;

    tbl[0]  = '{8'h41, 1, 0, 1};
    tbl[1]  = '{8'h42, 2, 0, 1};
    tbl[2]  = '{8'h0D, 0, 0, 0};
    tbl[3]  = '{8'h43, 1, 0, 1};
    tbl[4]  = '{8'h08, 0, 0, 1};
    tbl[5]  = '{8'h08, 0, 0, 0};
    tbl[6]  = '{8'h0A, 0, 1, 80};
    tbl[7]  = '{8'h07, 0, 1, 0};
    tbl[8]  = '{8'h7A, 1, 1, 1};
    tbl[9]  = '{8'h7F, 1, 1, 0};
    tbl[10] = '{8'h1F, 1, 1, 0};
    tbl[11] = '{8'h7E, 2, 1, 1};
    tbl[12] = '{8'h20, 3, 1, 1};

    intf.char_in    = 8'h00;
    intf.char_valid = 1'b0;

    // Power-up clear sweep
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b0;
    m_clear_all();
    settle();
    chk_eq("clr_all_count", obs_q.size() - rd, 2400);
    chk_eq("clr_all_span", obs_at(obs_q.size() - 1).cyc - obs_at(rd).cyc, 2399);
    check_writes("clr_all");
    chk_eq("clr_all_ready", int'(intf.char_ready), 1);
    check_cursor("clr_all_cursor", 0, 0);

    // Back-to-back 'A','B'
    n0 = obs_q.size();
    send(8'h41);
    send(8'h42);
    settle();
    w = obs_at(n0);
    chk_eq("ab_addr0", w.addr, 'h000);
    chk_eq("ab_data0", w.data, 'h41);
    n = w.cyc;
    w = obs_at(n0 + 1);
    chk_eq("ab_addr1", w.addr, 'h001);
    chk_eq("ab_data1", w.data, 'h42);
    chk_eq("ab_consecutive", w.cyc - n, 1);
    check_writes("ab");
    check_cursor("ab_cursor", 0, 2);

    // Line wrap after 80 printable characters
    send(8'h0C);
    settle();
    check_writes("ff1");
    for (int i = 0; i < NCOLS; i++) send(8'h58);
    n = 0;
    @(negedge clk);
    while (!intf.char_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk_eq("wrap_ready_low_cycles", n, 80);
    settle();
    check_writes("wrap");
    check_cursor("wrap_cursor", 1, 0);

    // LF on the bottom row wraps to row 0 and blanks it
    for (int i = 0; i < 28; i++) send(8'h0A);
    for (int i = 0; i < 5; i++) send(8'h61);
    settle();
    check_writes("to_bottom");
    check_cursor("bottom_cursor", 29, 5);
    n0 = obs_q.size();
    send(8'h0A);
    settle();
    chk_eq("lf_wrap_count", obs_q.size() - n0, 80);
    chk_eq("lf_wrap_first", obs_at(n0).addr, 'h000);
    chk_eq("lf_wrap_last", obs_at(n0 + 79).addr, 'h04F);
    check_writes("lf_wrap");
    check_cursor("lf_wrap_cursor", 0, 0);

    // 'H','I',BS,BS,BS
    n0 = obs_q.size();
    send(8'h48);
    send(8'h49);
    send(8'h08);
    send(8'h08);
    send(8'h08);
    settle();
    chk_eq("bs_count", obs_q.size() - n0, 4);
    chk_eq("bs_w0", obs_at(n0).addr * 256 + obs_at(n0).data, 'h00048);
    chk_eq("bs_w1", obs_at(n0 + 1).addr * 256 + obs_at(n0 + 1).data, 'h00149);
    chk_eq("bs_w2", obs_at(n0 + 2).addr * 256 + obs_at(n0 + 2).data, 'h00120);
    chk_eq("bs_w3", obs_at(n0 + 3).addr * 256 + obs_at(n0 + 3).data, 'h00020);
    check_writes("bs");
    check_cursor("bs_cursor", 0, 0);

    // Table of single characters from a cleared screen
    send(8'h0C);
    settle();
    check_writes("ff2");
    for (int i = 0; i < 13; i++) begin
      n0 = obs_q.size();
      send(tbl[i].c);
      settle();
      chk_eq($sformatf("tbl%0d_writes", i), obs_q.size() - n0, tbl[i].nwr);
      check_writes($sformatf("tbl%0d", i));
      check_cursor($sformatf("tbl%0d_cursor", i), tbl[i].row, tbl[i].col);
    end

    // Reset in the middle of a form-feed sweep
    send(8'h51);
    settle();
    check_writes("pre_ff");
    send(8'h0C);
    n = 0;
    while (obs_q.size() - rd < 1000 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) fail_now("ff_sweep_timeout");
    reset = 1'b1;
    #1;
    check_reset_state("mid_reset");
    @(negedge clk);
    rd = obs_q.size();
    exp_q.delete();
    reset = 1'b0;
    m_clear_all();
    settle();
    chk_eq("rst_sweep_first", obs_at(rd).addr, 0);
    chk_eq("rst_sweep_count", obs_q.size() - rd, 2400);
    check_writes("rst_sweep");
    n0 = obs_q.size();
    send(8'h07);
    settle();
    chk_eq("bel_no_write", obs_q.size() - n0, 0);
    chk_eq("bel_ready", int'(intf.char_ready), 1);
    check_cursor("bel_cursor", 0, 0);

    // Random stream against the model
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 70)      ch = 8'($urandom_range(32, 126));
      else if (r < 78) ch = 8'h0D;
      else if (r < 84) ch = 8'h0A;
      else if (r < 96) ch = 8'h08;
      else             ch = 8'($urandom_range(0, 31));
      if (ch == 8'h0C) ch = 8'h0D;
      send(ch);
      if ($urandom_range(0, 9) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    settle();
    check_writes("rand");
    check_cursor("rand_cursor", m_row, m_col);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
